// File: rtl/satarx_crc.sv
// Receive-side SATA CRC checker: strips the trailing CRC dword of each frame,
// forwards the data dwords and flags a CRC mismatch on the last one via TUSER.
module satarx_crc #(
  parameter logic [31:0] POLYNOMIAL   = 32'h04c1_1db7,
  parameter logic [31:0] INITIAL_CRC  = 32'h5232_5032,
  parameter logic        OPT_LOWPOWER = 1'b1
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TUSER,
  output logic        o_crc_err,
  output logic        o_short_err
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]  state_reg;
  logic [31:0] hold_reg;
  logic [31:0] crc_reg;
  logic [31:0] crc_next;
  logic        m_valid_reg;
  logic [31:0] m_data_reg;
  logic        m_last_reg;
  logic        m_user_reg;
  logic        crc_err_reg;
  logic        short_err_reg;
  logic        ostall;
  logic        accept;
  logic        crc_bad;

  // Serial MSB-first CRC update of one dword, unrolled into combinational logic.
  function automatic logic [31:0] adv(input logic [31:0] sreg_in, input logic [31:0] d);
    logic [31:0] sreg;
    sreg = sreg_in;
    for (int k = 0; k < 32; k++) begin
      if (sreg[31] ^ d[31-k])
        sreg = {sreg[30:0], 1'b0} ^ POLYNOMIAL;
      else
        sreg = {sreg[30:0], 1'b0};
    end
    return sreg;
  endfunction

  assign crc_next      = adv(crc_reg, hold_reg);
  assign crc_bad       = (crc_next != S_AXIS_TDATA);
  assign ostall        = m_valid_reg && !M_AXIS_TREADY;
  assign S_AXIS_TREADY = !S_AXI_ARESET && ((state_reg == S_EMPTY) || !ostall);
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;

  // Frame state: the held dword only becomes "data" once a later dword arrives.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_reg <= S_EMPTY;
      hold_reg  <= 32'h0;
      crc_reg   <= INITIAL_CRC;
    end else if (accept) begin
      if (state_reg == S_EMPTY) begin
        if (S_AXIS_TLAST) begin
          crc_reg <= INITIAL_CRC;
        end else begin
          hold_reg  <= S_AXIS_TDATA;
          state_reg <= S_HOLD;
        end
      end else if (S_AXIS_TLAST) begin
        crc_reg   <= INITIAL_CRC;
        state_reg <= S_EMPTY;
      end else begin
        hold_reg <= S_AXIS_TDATA;
        crc_reg  <= crc_next;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= 32'h0;
      m_last_reg  <= 1'b0;
      m_user_reg  <= 1'b0;
    end else if (!ostall) begin
      if (accept && (state_reg == S_HOLD)) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= hold_reg;
        m_last_reg  <= S_AXIS_TLAST;
        m_user_reg  <= S_AXIS_TLAST && crc_bad;
      end else begin
        m_valid_reg <= 1'b0;
        if (OPT_LOWPOWER) begin
          m_data_reg <= 32'h0;
          m_last_reg <= 1'b0;
          m_user_reg <= 1'b0;
        end
      end
    end
  end

  // Error pulses; a CRC-only frame never reaches the CRC compare, so they are exclusive.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      crc_err_reg   <= 1'b0;
      short_err_reg <= 1'b0;
    end else begin
      crc_err_reg   <= accept && (state_reg == S_HOLD) && S_AXIS_TLAST && crc_bad;
      short_err_reg <= accept && (state_reg == S_EMPTY) && S_AXIS_TLAST;
    end
  end

  assign M_AXIS_TVALID = m_valid_reg;
  assign M_AXIS_TDATA  = m_data_reg;
  assign M_AXIS_TLAST  = m_last_reg;
  assign M_AXIS_TUSER  = m_user_reg;
  assign o_crc_err     = crc_err_reg;
  assign o_short_err   = short_err_reg;

endmodule
